pfl_reconf_ctrl: RTL and testbench
==================================

// Module: pfl_reconf_ctrl
// PURPOSE
//  Downstream consumer of the flash table-read stage. Requests the table read and latches the decoded image page.
//  Then hands the shared flash bus to the PFL and pulses a PFL reconfiguration of the FPGA from that page.
//  Supervises CONF_DONE with timeout and retry, and reports done/error status.
// PARAMETERS
//  STARTUP_DLY   16'd1000  clk cycles after reset release before the table-read request
//  RD_TIMEOUT    16'd256   max cycles waiting for rd_done; on expiry page = DEFAULT_PAGE
//  SETTLE_CYC    8'd8      cycles after request release before granting the bus (reader tristates)
//  NRECONF_CYC   8'd16     width of the pfl_nreconfigure low pulse
//  CONF_TIMEOUT  24'd1000000  max cycles waiting for conf_done per attempt
//  MAX_RETRY     2'd2      re-attempts on the same page after the first failure
//  DEFAULT_PAGE  2'b00     page used when no valid table word arrives
// PORTS
//  clk                       in   1  system clock
//  sys_reset                 in   1  asynchronous reset, active-high
//  fc_rd_req                 out  1  table-read request to reader, active-low (0 = read)
//  rd_done                   in   1  one-cycle pulse from reader: pfl_str is valid
//  pfl_str                   in   2  decoded image page from reader
//  pfl_flash_access_request  in   1  PFL asks for the flash bus
//  pfl_flash_access_granted  out  1  bus granted to PFL
//  pfl_page_sel              out  2  page presented to PFL
//  pfl_nreconfigure          out  1  PFL reconfigure trigger, active-low
//  conf_done                 in   1  FPGA CONF_DONE; async input, 2-flop synchronised
//  busy                      out  1  high from reset release until DONE or FAIL
//  err                       out  1  sticky failure flag
// BEHAVIOUR
//  Reset values: fc_rd_req=1, granted=0, page_sel=DEFAULT_PAGE, nreconfigure=1, busy=1, err=0, all counters 0.
//  All outputs are registered. Counters are 24 bit and saturate, never wrap.
//  States: STARTUP, REQ, SETTLE, GRANT, RECONF, WAIT_DONE, DONE, FAIL.
//  STARTUP: count STARTUP_DLY cycles, then go to REQ.
//  REQ: fc_rd_req=0.
//   - rd_done=1: latch pfl_str into page_sel the same edge, fc_rd_req<=1, go to SETTLE.
//   - RD_TIMEOUT elapsed without rd_done: page_sel=DEFAULT_PAGE, fc_rd_req<=1, go to SETTLE.
//   - rd_done in the same cycle as timeout expiry: rd_done wins.
//  SETTLE: SETTLE_CYC cycles with fc_rd_req=1 and no grant, then go to GRANT.
//  GRANT: granted<=1 once pfl_flash_access_request=1; next cycle go to RECONF. Grant is held until DONE/FAIL.
//  RECONF: nreconfigure=0 for exactly NRECONF_CYC cycles, then 1; go to WAIT_DONE.
//  WAIT_DONE:
//   - synced conf_done=1: go to DONE.
//   - CONF_TIMEOUT elapsed: retry_cnt++ and go to RECONF (same page) while retry_cnt < MAX_RETRY; otherwise see CONFIGURATION.
//   - conf_done and timeout in the same cycle: conf_done wins.
//  DONE: busy=0, err=0, granted=0. Terminal until reset.
//  FAIL: busy=0, err=1, granted=0, nreconfigure=1. Terminal until reset.
//  Late rd_done pulses outside REQ are ignored. pfl_str is sampled only on the rd_done edge.
//  sys_reset mid-operation: all outputs return to reset values immediately (async); nreconfigure pulse aborts high.
//  Total attempts without fallback = 1 + MAX_RETRY.
// CONFIGURATION
//  FACTORY_FALLBACK_EN defined:
//   - on retry exhaustion with page_sel != 2'b00: page_sel<=2'b00, retry_cnt<=0, one further RECONF/WAIT_DONE attempt.
//   - failure of that attempt goes to FAIL. err is also set in DONE when reached via fallback.
//  Undefined: retry exhaustion goes straight to FAIL. page_sel never changes after latch.
// TESTING
//  T1 reset release, rd_done pulse with pfl_str=2'b11 at cycle 1010, access_request=1, conf_done after 50 cycles
//     -> fc_rd_req low 1000..1010, page_sel=3, 16-cycle nreconfigure pulse, DONE busy=0 err=0.
//  T2 no rd_done -> fc_rd_req released after 256 cycles, page_sel=2'b00, reconfig proceeds.
//  T3 conf_done never rises, MAX_RETRY=2, macro off
//     -> exactly 3 nreconfigure pulses spaced CONF_TIMEOUT apart, then FAIL err=1 granted=0.
//  T4 same as T3 with FACTORY_FALLBACK_EN, page 2'b10 -> 3 pulses on page 2, 4th pulse on page 0, then FAIL err=1.
//  T5 assert sys_reset during RECONF pulse -> nreconfigure=1, fc_rd_req=1, granted=0 immediately; full sequence restarts.
//  T6 rd_done coincident with RD_TIMEOUT expiry, pfl_str=2'b01 -> page_sel=2'b01; extra rd_done in WAIT_DONE ignored.

Source files
------------

// File: rtl/pfl_reconf_ctrl.sv
// pfl_reconf_ctrl: requests the flash table read, latches the decoded image
// page, hands the shared flash bus to the PFL and triggers a reconfiguration
// from that page, then supervises CONF_DONE with timeout and retry.
// Optional feature macro FACTORY_FALLBACK_EN: after the retries on a non-zero
// page are exhausted, make one last attempt from the factory page 2'b00.
module pfl_reconf_ctrl #(
  parameter logic [15:0] STARTUP_DLY  = 16'd1000,
  parameter logic [15:0] RD_TIMEOUT   = 16'd256,
  parameter logic [7:0]  SETTLE_CYC   = 8'd8,
  parameter logic [7:0]  NRECONF_CYC  = 8'd16,
  parameter logic [23:0] CONF_TIMEOUT = 24'd1000000,
  parameter logic [1:0]  MAX_RETRY    = 2'd2,
  parameter logic [1:0]  DEFAULT_PAGE = 2'b00
) (
  input  logic       clk,
  input  logic       sys_reset,
  output logic       fc_rd_req,
  input  logic       rd_done,
  input  logic [1:0] pfl_str,
  input  logic       pfl_flash_access_request,
  output logic       pfl_flash_access_granted,
  output logic [1:0] pfl_page_sel,
  output logic       pfl_nreconfigure,
  input  logic       conf_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_STARTUP, ST_REQ, ST_SETTLE, ST_GRANT,
    ST_RECONF, ST_WAIT_DONE, ST_DONE, ST_FAIL
  } state_t;

  // Terminal counts: a phase of length L ends on the edge where cnt == L-1.
  localparam logic [23:0] STARTUP_LIM = 24'(STARTUP_DLY) - 24'd1;
  localparam logic [23:0] RD_LIM      = 24'(RD_TIMEOUT) - 24'd1;
  localparam logic [23:0] SETTLE_LIM  = 24'(SETTLE_CYC) - 24'd1;
  localparam logic [23:0] NRECONF_LIM = 24'(NRECONF_CYC) - 24'd1;
  localparam logic [23:0] CONF_LIM    = CONF_TIMEOUT - 24'd1;
  localparam logic [23:0] RETRY_MAX   = 24'(MAX_RETRY);

  state_t      state, state_nx;
  logic [23:0] cnt;
  logic [23:0] retry_cnt, retry_nx;
  logic        fb, fb_nx;
  logic        conf_done_p0, conf_done_p1;
  logic [1:0]  page_nx;
  logic        fc_nx, granted_nx, nreconf_nx, busy_nx, err_nx;

  function automatic logic [23:0] sat_inc(input logic [23:0] v);
    return (v == 24'hFF_FFFF) ? v : v + 24'd1;
  endfunction

  // conf_done crosses in asynchronously: two-flop synchroniser
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      conf_done_p0 <= 1'b0;
      conf_done_p1 <= 1'b0;
    end else begin
      conf_done_p0 <= conf_done;
      conf_done_p1 <= conf_done_p0;
    end
  end

  // State register and the phase counter, which restarts on every state change
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= ST_STARTUP;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? 24'd0 : sat_inc(cnt);
    end
  end

  // Next-state decode; a valid event always beats a coincident timeout
  always_comb begin
    state_nx = state;
    case (state)
      ST_STARTUP:   if (cnt == STARTUP_LIM) state_nx = ST_REQ;
      ST_REQ:       if (rd_done || cnt == RD_LIM) state_nx = ST_SETTLE;
      ST_SETTLE:    if (cnt == SETTLE_LIM) state_nx = ST_GRANT;
      ST_GRANT:     if (pfl_flash_access_request) state_nx = ST_RECONF;
      ST_RECONF:    if (cnt == NRECONF_LIM) state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (conf_done_p1) begin
          state_nx = ST_DONE;
        end else if (cnt == CONF_LIM) begin
          if (!fb && retry_cnt < RETRY_MAX) state_nx = ST_RECONF;
`ifdef FACTORY_FALLBACK_EN
          else if (!fb && pfl_page_sel != 2'b00) state_nx = ST_RECONF;
`endif
          else state_nx = ST_FAIL;
        end
      end
      ST_DONE:      state_nx = ST_DONE;
      ST_FAIL:      state_nx = ST_FAIL;
      default:      state_nx = ST_STARTUP;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken
  always_comb begin
    page_nx  = pfl_page_sel;
    retry_nx = retry_cnt;
    fb_nx    = fb;
    if (state == ST_REQ && state_nx == ST_SETTLE)
      page_nx = rd_done ? pfl_str : DEFAULT_PAGE;
    if (state == ST_WAIT_DONE && state_nx == ST_RECONF) begin
`ifdef FACTORY_FALLBACK_EN
      if (retry_cnt < RETRY_MAX) begin
        retry_nx = sat_inc(retry_cnt);
      end else begin
        page_nx  = 2'b00;
        retry_nx = '0;
        fb_nx    = 1'b1;
      end
`else
      retry_nx = sat_inc(retry_cnt);
`endif
    end
    fc_nx      = (state_nx != ST_REQ);
    granted_nx = (state_nx == ST_RECONF) || (state_nx == ST_WAIT_DONE);
    nreconf_nx = (state_nx != ST_RECONF);
    busy_nx    = (state_nx != ST_DONE) && (state_nx != ST_FAIL);
    err_nx     = err || (state_nx == ST_FAIL) || (state_nx == ST_DONE && fb_nx);
  end

  // Output and bookkeeping registers; reset drops the reconfigure pulse at once
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      fc_rd_req                <= 1'b1;
      pfl_flash_access_granted <= 1'b0;
      pfl_page_sel             <= DEFAULT_PAGE;
      pfl_nreconfigure         <= 1'b1;
      busy                     <= 1'b1;
      err                      <= 1'b0;
      retry_cnt                <= '0;
      fb                       <= 1'b0;
    end else begin
      fc_rd_req                <= fc_nx;
      pfl_flash_access_granted <= granted_nx;
      pfl_page_sel             <= page_nx;
      pfl_nreconfigure         <= nreconf_nx;
      busy                     <= busy_nx;
      err                      <= err_nx;
      retry_cnt                <= retry_nx;
      fb                       <= fb_nx;
    end
  end

endmodule

// File: tb/tb_pfl_reconf_ctrl.sv
// Bench for pfl_reconf_ctrl with shortened timing parameters. Each scenario
// is planned as absolute edge numbers (rd_done, access request, conf_done);
// a timeline model turns the plan into expected output windows.
module tb_pfl_reconf_ctrl;

  localparam int D   = 30;
  localparam int RT  = 20;
  localparam int S   = 4;
  localparam int N   = 5;
  localparam int CT  = 40;
  localparam int MR  = 2;
  localparam logic [1:0] DEF = 2'b00;
`ifdef FACTORY_FALLBACK_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic sys_reset = 1'b1;
  logic fc_rd_req, rd_done, pfl_flash_access_request, pfl_flash_access_granted;
  logic pfl_nreconfigure, conf_done, busy, err;
  logic [1:0] pfl_str, pfl_page_sel;

  always #5 clk = ~clk;

  pfl_reconf_ctrl #(
    .STARTUP_DLY(16'(D)), .RD_TIMEOUT(16'(RT)), .SETTLE_CYC(8'(S)),
    .NRECONF_CYC(8'(N)), .CONF_TIMEOUT(24'(CT)), .MAX_RETRY(2'(MR)),
    .DEFAULT_PAGE(DEF)
  ) dut (
    .clk(clk), .sys_reset(sys_reset), .fc_rd_req(fc_rd_req), .rd_done(rd_done),
    .pfl_str(pfl_str), .pfl_flash_access_request(pfl_flash_access_request),
    .pfl_flash_access_granted(pfl_flash_access_granted),
    .pfl_page_sel(pfl_page_sel), .pfl_nreconfigure(pfl_nreconfigure),
    .conf_done(conf_done), .busy(busy), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scenario plan: edge at which each input is seen by the DUT
  int s_e, s_e2, s_rq, s_crel, s_c;
  logic [1:0] s_str;
  // Model results
  int m_tset, m_tgr, m_tend, m_fbedge;
  logic [1:0] m_page0;
  bit m_err;
  int pulses[$];

  // Vector layout {fc_rd_req, granted, page_sel[1:0], nreconfigure, busy, err}
  localparam logic [6:0] RST_VEC = {1'b1, 1'b0, DEF, 1'b1, 1'b1, 1'b0};

  function automatic logic [6:0] dut_vec();
    return {fc_rd_req, pfl_flash_access_granted, pfl_page_sel,
            pfl_nreconfigure, busy, err};
  endfunction

  // Timeline of the whole sequence from the plan
  task automatic build_model();
    int tg, p, tw, te, ce, retries;
    logic [1:0] pg;
    bit fb;
    pulses.delete();
    m_fbedge = -1;
    if (s_e >= D + 1 && s_e <= D + RT) begin
      m_tset = s_e; m_page0 = s_str;
    end else begin
      m_tset = D + RT; m_page0 = DEF;
    end
    tg    = m_tset + S;
    m_tgr = (s_rq > tg + 1) ? s_rq : tg + 1;
    s_c   = (s_crel >= 0) ? m_tgr + s_crel : -1;
    p = m_tgr; pg = m_page0; fb = 1'b0; retries = 0;
    while (1) begin
      pulses.push_back(p);
      tw = p + N;
      te = tw + CT;
      ce = (s_c < 0) ? NEVER : ((s_c + 2 > tw + 1) ? s_c + 2 : tw + 1);
      if (ce <= te) begin
        m_tend = ce; m_err = fb; break;
      end
      if (!fb && retries < MR) begin
        retries++; p = te;
      end else if (FB_EN && !fb && pg != 2'b00) begin
        fb = 1'b1; pg = 2'b00; m_fbedge = te; p = te;
      end else begin
        m_tend = te; m_err = 1'b1; break;
      end
    end
  endtask

  function automatic logic [6:0] exp_vec(input int k);
    logic fc, gr, nrec, bz, er;
    logic [1:0] pg;
    fc = !(k >= D && k < m_tset);
    gr = (k >= m_tgr && k < m_tend);
    if (k < m_tset) pg = DEF;
    else if (m_fbedge >= 0 && k >= m_fbedge) pg = 2'b00;
    else pg = m_page0;
    nrec = 1'b1;
    foreach (pulses[i]) if (k >= pulses[i] && k < pulses[i] + N) nrec = 1'b0;
    bz = (k < m_tend);
    er = (k >= m_tend) && m_err;
    return {fc, gr, pg, nrec, bz, er};
  endfunction

  // Inputs as the DUT must see them at edge k
  task automatic drive(input int k);
    rd_done = (k == s_e) || (k == s_e2);
    pfl_str = (k == s_e) ? s_str : 2'($urandom);
    pfl_flash_access_request = (k >= s_rq);
    conf_done = (s_c >= 0) && (k >= s_c);
  endtask

  task automatic run_scn(input int id, input int stop);
    sys_reset = 1'b1;
    rd_done = 1'b0; pfl_str = 2'b00; pfl_flash_access_request = 1'b0; conf_done = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("s%0d.reset", id), 32'(dut_vec()), 32'(RST_VEC));
    @(posedge clk); #1;
    drive(1);
    sys_reset = 1'b0;
    for (int k = 1; k <= stop; k++) begin
      @(posedge clk); #1;
      chk($sformatf("s%0d.k%0d", id, k), 32'(dut_vec()), 32'(exp_vec(k)));
      if (k < stop) drive(k + 1);
    end
  endtask

  task automatic plan(input int e, input logic [1:0] str, input int rq, input int crel);
    s_e = e; s_str = str; s_rq = rq; s_crel = crel; s_e2 = -1;
    build_model();
  endtask

  initial begin
    // Valid table word, conf_done well inside the first attempt
    plan(D + 10, 2'b11, 1, N + 20);
    run_scn(0, m_tend + 4);
    chk("s0.page_latched", 32'(pfl_page_sel), 32'd3);
    // No rd_done: read timeout, default page
    plan(-1, 2'b10, D + RT + S + 7, N + 10);
    run_scn(1, m_tend + 4);
    // conf_done never rises on page 2: retries (and fallback if enabled) then FAIL
    plan(D + 3, 2'b10, 1, -1);
    run_scn(2, m_tend + 4);
    chk("s2.pulses", 32'(pulses.size()), FB_EN ? 32'd4 : 32'd3);
    chk("s2.err", 32'(err), 32'd1);
    // rd_done coincident with read timeout, stray rd_done later in WAIT_DONE
    plan(D + RT, 2'b01, 1, N + CT + N + 5);
    s_e2 = m_tgr + N + 3;
    run_scn(3, m_tend + 4);
    chk("s3.page", 32'(pfl_page_sel), 32'd1);
    // conf_done reaching the FSM on the very timeout edge wins
    plan(D + 4, 2'b01, 1, N + CT - 2);
    run_scn(4, m_tend + 4);
    chk("s4.tend", 32'(m_tend == m_tgr + N + CT), 32'd1);
    // one cycle later: timeout wins, retry, then done at once
    plan(D + 4, 2'b01, 1, N + CT - 1);
    run_scn(5, m_tend + 4);
    // rd_done seen while still in STARTUP is ignored
    plan(D, 2'b11, 1, 3);
    run_scn(6, m_tend + 4);
    // Reset asserted in the middle of the reconfigure pulse
    plan(D + 2, 2'b10, 1, N + 8);
    run_scn(7, pulses[0] + 2);
    chk("s7.pulse_low", 32'(pfl_nreconfigure), 32'd0);
    #2 sys_reset = 1'b1;
    #1 chk("s7.async_reset", 32'(dut_vec()), 32'(RST_VEC));
    run_scn(8, m_tend + 4);
    // Randomised plans
    for (int r = 0; r < 10; r++) begin
      int e, rq, crel;
      e    = ($urandom_range(0, 3) == 0) ? -1 : D - 3 + int'($urandom_range(0, RT + 6));
      rq   = int'($urandom_range(1, D + RT + S + 15));
      crel = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 3 * (N + CT) + 10));
      plan(e, 2'($urandom), rq, crel);
      run_scn(10 + r, m_tend + 4);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
